regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised multi-port integer register file for the superscalar core, successor to the fixed 6-read/2-write file.
- Adds configurable port counts, depth and width; optional same-cycle write-to-read bypass; per-register pending (scoreboard) bits; deterministic write-port priority.
- Adds a post-reset clear sweep, sized like SRAM initialisation, during which the block reports not-ready.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 128, number of architectural/physical registers; power of two, >= 2.
- NUM_RD, 6, number of read ports.
- NUM_WR, 2, number of write ports.
- NUM_RSV, 2, number of reservation (set-pending) ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see the array only.
- CLR_PER_CYC, 8, registers cleared per cycle during the init sweep; must divide NUM_REGS.
- Localparam ADDR_W = $clog2(NUM_REGS).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- o_ready  out  1  high when the sweep is complete and the block accepts writes/reservations.
- i_r_addr[NUM_RD]  in  ADDR_W each  read addresses.
- o_r_data[NUM_RD]  out  DATA_W each  combinational read data.
- o_r_pend[NUM_RD]  out  1 each  pending bit of the addressed register.
- i_w_en[NUM_WR]  in  1 each  write enables.
- i_w_addr[NUM_WR]  in  ADDR_W each  write addresses.
- i_w_data[NUM_WR]  in  DATA_W each  write data.
- i_rsv_en[NUM_RSV]  in  1 each  reserve enables; mark the register pending.
- i_rsv_addr[NUM_RSV]  in  ADDR_W each  reserve addresses.

Behaviour:
- Two-state FSM: INIT, RUN.
- i_rst high at any edge, including mid-sweep or mid-operation:
  - Next state INIT.
  - Clear counter = 0.
  - All pending bits = 0.
  - o_ready = 0.
- INIT state:
  - Each cycle, zero registers counter*CLR_PER_CYC .. +CLR_PER_CYC-1, then increment the counter.
  - After the last group, go to RUN. o_ready rises the cycle after the final group is cleared.
  - Sweep length is exactly NUM_REGS/CLR_PER_CYC cycles after reset deasserts (default 16).
  - Writes and reservations are ignored.
  - All o_r_data = 0 and all o_r_pend = 0.
- RUN state:
  - Reads are combinational: o_r_data[i] = reg[i_r_addr[i]], o_r_pend[i] = pend[i_r_addr[i]].
  - Writes commit at the posedge.
  - If several enabled write ports target the same address, the highest-index port wins.
  - If BYPASS=1 and any enabled write port targets a read address (other than 0) in the same cycle, that read returns the winning write data. o_r_pend is not bypassed.
  - Register 0 always reads 0. Writes to 0 are dropped. Reserve of 0 is dropped. pend[0] is always 0.
  - Pending bit update per register at the posedge:
    - Any enabled reserve targets it: set to 1. Reserve beats a same-cycle write, because a new producer overrides the old one.
    - Otherwise, any enabled write targets it: clear to 0.
    - Otherwise: hold.
  - A write does not require a prior reservation. A reserve does not alter data.
- No X propagation: unused ports with enable low have no effect regardless of address or data values.

Test Plan:
- Reset sweep: assert i_rst 1 cycle, then release -> o_ready = 0 for exactly 16 cycles, then 1. During the sweep, write 0xDEAD to r5 -> after ready, r5 reads 0x0.
- Basic write/read: write r7 = 0x1234 via port 0 -> next cycle all 6 read ports addressed to r7 return 0x1234. Write r0 = 0xFFFF -> r0 reads 0.
- Port priority and bypass: same cycle, port0 writes r9 = 0xAAAA and port1 writes r9 = 0xBBBB -> same-cycle read of r9 = 0xBBBB with BYPASS=1 and 0 with BYPASS=0. Next cycle r9 = 0xBBBB in both configurations.
- Scoreboard: reserve r3 -> next cycle o_r_pend = 1. Write r3 = 0x55 -> following cycle pend = 0 and data = 0x55.
- Reserve/write collision: pend[r4] = 1; same cycle reserve r4 and write r4 = 0x77 -> pend stays 1 and data = 0x77.
- Mid-operation reset: in RUN with r10 = 0x99 and pend[r10] = 1, pulse i_rst -> o_ready drops the next cycle, pend[r10] = 0, and after the sweep r10 = 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised multi-port register file with per-register pending (scoreboard)
// bits, optional same-cycle write-to-read bypass and a post-reset clear sweep.
module regfile_scoreboard #(
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 128,
   parameter int NUM_RD      = 6,
   parameter int NUM_WR      = 2,
   parameter int NUM_RSV     = 2,
   parameter int BYPASS      = 1,
   parameter int CLR_PER_CYC = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   output logic                        o_ready,
   input  logic [$clog2(NUM_REGS)-1:0] i_r_addr   [NUM_RD],
   output logic [DATA_W-1:0]           o_r_data   [NUM_RD],
   output logic                        o_r_pend   [NUM_RD],
   input  logic                        i_w_en     [NUM_WR],
   input  logic [$clog2(NUM_REGS)-1:0] i_w_addr   [NUM_WR],
   input  logic [DATA_W-1:0]           i_w_data   [NUM_WR],
   input  logic                        i_rsv_en   [NUM_RSV],
   input  logic [$clog2(NUM_REGS)-1:0] i_rsv_addr [NUM_RSV]
);

   localparam int ADDR_W  = $clog2(NUM_REGS);
   localparam int NUM_GRP = NUM_REGS / CLR_PER_CYC;
   localparam int CNT_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
   localparam int unsigned CPC_U = CLR_PER_CYC;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    clr_cnt;
   logic [NUM_REGS-1:0] pend;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic                accept;

   // Writes and reservations only take effect in RUN with reset low.
   assign accept = (state == S_RUN) && !i_rst;

   // Control FSM: sweep sequencing, ready flag and pending-bit scoreboard.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= S_INIT;
         clr_cnt <= '0;
         pend    <= '0;
         o_ready <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == CNT_W'(NUM_GRP - 1)) begin
                  state   <= S_RUN;
                  o_ready <= 1'b1;
               end
            end
            S_RUN: begin
               // Reserves are applied after writes so a same-cycle reserve wins.
               for (int unsigned w = 0; w < NUM_WR; w++) begin
                  if (i_w_en[w] && i_w_addr[w] != '0)
                     pend[i_w_addr[w]] <= 1'b0;
               end
               for (int unsigned r = 0; r < NUM_RSV; r++) begin
                  if (i_rsv_en[r] && i_rsv_addr[r] != '0)
                     pend[i_rsv_addr[r]] <= 1'b1;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

   // Storage array: one clear group per INIT cycle, port writes in RUN.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (state == S_INIT) begin
            for (int unsigned j = 0; j < CPC_U; j++)
               regs[ADDR_W'(32'(clr_cnt) * CPC_U + j)] <= '0;
         end else begin
            // Ascending port order: the highest-index enabled port lands last.
            for (int unsigned w = 0; w < NUM_WR; w++) begin
               if (i_w_en[w] && i_w_addr[w] != '0)
                  regs[i_w_addr[w]] <= i_w_data[w];
            end
         end
      end
   end

   // Combinational read ports with optional forwarding of same-cycle writes.
   always_comb begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         o_r_data[i] = '0;
         o_r_pend[i] = 1'b0;
         if (state == S_RUN && i_r_addr[i] != '0) begin
            o_r_data[i] = regs[i_r_addr[i]];
            o_r_pend[i] = pend[i_r_addr[i]];
            if (BYPASS != 0 && accept) begin
               for (int unsigned w = 0; w < NUM_WR; w++) begin
                  if (i_w_en[w] && i_w_addr[w] == i_r_addr[i])
                     o_r_data[i] = i_w_data[w];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// random traffic, checked against a behavioural model of the register file.
module tb_regfile_scoreboard;

   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 128;
   localparam int NUM_RD   = 6;
   localparam int NUM_WR   = 2;
   localparam int NUM_RSV  = 2;
   localparam int AW       = 7;
   localparam int NUM_GRP  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [AW-1:0]     r_addr   [NUM_RD];
   logic              w_en     [NUM_WR];
   logic [AW-1:0]     w_addr   [NUM_WR];
   logic [DATA_W-1:0] w_data   [NUM_WR];
   logic              rsv_en   [NUM_RSV];
   logic [AW-1:0]     rsv_addr [NUM_RSV];

   logic              ready_b,  ready_nb;
   logic [DATA_W-1:0] rd_b [NUM_RD], rd_nb [NUM_RD];
   logic              rp_b [NUM_RD], rp_nb [NUM_RD];

   regfile_scoreboard #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD),
      .NUM_WR(NUM_WR), .NUM_RSV(NUM_RSV), .BYPASS(1), .CLR_PER_CYC(8)) dut_b (
      .i_clk(clk), .i_rst(rst), .o_ready(ready_b),
      .i_r_addr(r_addr), .o_r_data(rd_b), .o_r_pend(rp_b),
      .i_w_en(w_en), .i_w_addr(w_addr), .i_w_data(w_data),
      .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr));

   regfile_scoreboard #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD),
      .NUM_WR(NUM_WR), .NUM_RSV(NUM_RSV), .BYPASS(0), .CLR_PER_CYC(8)) dut_nb (
      .i_clk(clk), .i_rst(rst), .o_ready(ready_nb),
      .i_r_addr(r_addr), .o_r_data(rd_nb), .o_r_pend(rp_nb),
      .i_w_en(w_en), .i_w_addr(w_addr), .i_w_data(w_data),
      .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr));

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: architectural contents, pending flags, readiness.
   logic [DATA_W-1:0] mregs [NUM_REGS];
   bit                mpend [NUM_REGS];
   bit                mready = 1'b0;
   int                sweep_left = NUM_GRP;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input logic [AW-1:0] a, input bit byp);
      if (!mready || a == '0) return '0;
      if (byp && !rst) begin
         for (int w = NUM_WR - 1; w >= 0; w--)
            if (w_en[w] && w_addr[w] == a) return w_data[w];
      end
      return mregs[a];
   endfunction

   function automatic bit exp_pend(input logic [AW-1:0] a);
      if (!mready) return 1'b0;
      return mpend[a];
   endfunction

   task automatic model_edge();
      if (rst) begin
         mready     = 1'b0;
         sweep_left = NUM_GRP;
         for (int r = 0; r < NUM_REGS; r++) mpend[r] = 1'b0;
      end else if (!mready) begin
         sweep_left--;
         if (sweep_left == 0) begin
            for (int r = 0; r < NUM_REGS; r++) mregs[r] = '0;
            mready = 1'b1;
         end
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            bit hit_r;
            bit hit_w;
            hit_r = 1'b0;
            hit_w = 1'b0;
            for (int p = 0; p < NUM_RSV; p++)
               if (rsv_en[p] && rsv_addr[p] == AW'(r)) hit_r = 1'b1;
            for (int w = NUM_WR - 1; w >= 0; w--) begin
               if (w_en[w] && w_addr[w] == AW'(r)) begin
                  if (!hit_w) mregs[r] = w_data[w];
                  hit_w = 1'b1;
               end
            end
            if (hit_r) mpend[r] = 1'b1;
            else if (hit_w) mpend[r] = 1'b0;
         end
      end
   endtask

   task automatic check_reads();
      for (int i = 0; i < NUM_RD; i++) begin
         chk($sformatf("rd_b%0d", i),  rd_b[i],       exp_data(r_addr[i], 1'b1));
         chk($sformatf("rd_nb%0d", i), rd_nb[i],      exp_data(r_addr[i], 1'b0));
         chk($sformatf("rp_b%0d", i),  32'(rp_b[i]),  32'(exp_pend(r_addr[i])));
         chk($sformatf("rp_nb%0d", i), 32'(rp_nb[i]), 32'(exp_pend(r_addr[i])));
      end
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      #1;
      check_reads();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("ready_b",  32'(ready_b),  32'(mready));
      chk("ready_nb", 32'(ready_nb), 32'(mready));
   endtask

   task automatic idle();
      rst = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
         w_en[w] = 1'b0; w_addr[w] = '0; w_data[w] = '0;
      end
      for (int p = 0; p < NUM_RSV; p++) begin
         rsv_en[p] = 1'b0; rsv_addr[p] = '0;
      end
   endtask

   task automatic all_raddr(input logic [AW-1:0] a);
      for (int i = 0; i < NUM_RD; i++) r_addr[i] = a;
   endtask

   task automatic wr(input int port, input logic [AW-1:0] a, input logic [31:0] d);
      w_en[port] = 1'b1; w_addr[port] = a; w_data[port] = d;
   endtask

   task automatic rsv(input int port, input logic [AW-1:0] a);
      rsv_en[port] = 1'b1; rsv_addr[port] = a;
   endtask

   // Runs the sweep after reset release; returns the number of not-ready cycles.
   task automatic run_sweep(output int cnt, input bit poke_r5);
      cnt = 0;
      while (!ready_b && cnt < 40) begin
         idle();
         if (poke_r5 && cnt == 3) wr(0, 7'd5, 32'hDEAD);
         if (cnt == 5) rsv(1, 7'd5);
         step();
         cnt++;
      end
      idle();
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NUM_REGS - 1));
      return AW'($urandom_range(0, 15));
   endfunction

   initial begin
      int cnt;
      idle();
      all_raddr('0);
      rst = 1'b1;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("ready_after_reset", 32'(ready_b), 32'd0);

      // Sweep length and write suppression during the sweep.
      rst = 1'b0;
      run_sweep(cnt, 1'b1);
      chk("sweep_len", 32'(cnt), 32'd16);
      all_raddr(7'd5);
      #1 chk("r5_after_sweep", rd_b[0], 32'h0);
      chk("r5_pend_after_sweep", 32'(rp_b[0]), 32'd0);
      step();

      // Basic write and read on every port; register 0 stays zero.
      wr(0, 7'd7, 32'h1234);
      step();
      idle();
      all_raddr(7'd7);
      #1;
      for (int i = 0; i < NUM_RD; i++) chk($sformatf("r7_port%0d", i), rd_b[i], 32'h1234);
      wr(1, 7'd0, 32'hFFFF);
      step();
      idle();
      all_raddr(7'd0);
      #1 chk("r0_zero", rd_b[2], 32'h0);
      step();

      // Write-port priority and same-cycle bypass.
      wr(0, 7'd9, 32'hAAAA);
      wr(1, 7'd9, 32'hBBBB);
      all_raddr(7'd9);
      #1 chk("r9_bypass", rd_b[0], 32'hBBBB);
      chk("r9_nobypass", rd_nb[0], 32'h0);
      step();
      idle();
      #1 chk("r9_next_b", rd_b[1], 32'hBBBB);
      chk("r9_next_nb", rd_nb[1], 32'hBBBB);
      step();

      // Reserve sets pending; a later write clears it.
      rsv(0, 7'd3);
      step();
      idle();
      all_raddr(7'd3);
      #1 chk("r3_pend_set", 32'(rp_b[0]), 32'd1);
      wr(0, 7'd3, 32'h55);
      step();
      idle();
      #1 chk("r3_pend_clr", 32'(rp_b[0]), 32'd0);
      chk("r3_data", rd_b[0], 32'h55);
      step();

      // Reserve and write colliding on the same register.
      rsv(1, 7'd4);
      step();
      idle();
      rsv(0, 7'd4);
      wr(1, 7'd4, 32'h77);
      step();
      idle();
      all_raddr(7'd4);
      #1 chk("r4_pend_kept", 32'(rp_b[3]), 32'd1);
      chk("r4_data", rd_nb[3], 32'h77);
      step();

      // Reset in the middle of operation.
      wr(0, 7'd10, 32'h99);
      rsv(0, 7'd10);
      step();
      idle();
      all_raddr(7'd10);
      #1 chk("r10_pend_before", 32'(rp_b[0]), 32'd1);
      rst = 1'b1;
      step();
      chk("ready_drop", 32'(ready_b), 32'd0);
      rst = 1'b0;
      run_sweep(cnt, 1'b0);
      chk("sweep_len2", 32'(cnt), 32'd16);
      all_raddr(7'd10);
      #1 chk("r10_cleared", rd_b[0], 32'h0);
      chk("r10_pend_cleared", 32'(rp_b[0]), 32'd0);
      step();

      // Random traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 149) == 0);
         for (int i = 0; i < NUM_RD; i++) r_addr[i] = rand_addr();
         for (int w = 0; w < NUM_WR; w++) begin
            w_en[w]   = ($urandom_range(0, 1) == 1);
            w_addr[w] = rand_addr();
            w_data[w] = $urandom;
         end
         for (int p = 0; p < NUM_RSV; p++) begin
            rsv_en[p]   = ($urandom_range(0, 2) == 0);
            rsv_addr[p] = rand_addr();
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
